// File: rtl/z_core_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : z_core_mult_ctrl (with z_core_mult_unit)
//  Purpose  : RV32M MUL/MULH/MULHSU/MULHU sequencer around a multicycle
//             combinational 32x32->64 multiplier.
//  Revision : 1.0
// ============================================================================

module z_core_mult_unit (
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic        op1_signed,
    input  logic        op2_signed,
    output logic [63:0] result
);
    logic [63:0] w_op1_ext;
    logic [63:0] w_op2_ext;

    // Low 64 bits of the extended product equal the exact 32x32 product
    assign w_op1_ext = {{32{op1_signed & op1[31]}}, op1};
    assign w_op2_ext = {{32{op2_signed & op2[31]}}, op2};
    assign result    = w_op1_ext * w_op2_ext;
endmodule

module z_core_mult_ctrl #(
    parameter int MULT_CYCLES = 2,
    parameter int TAG_W       = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    localparam logic [3:0] CNT_INIT = 4'(MULT_CYCLES - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [31:0]      rs1_q, rs1_d;
    logic [31:0]      rs2_q, rs2_d;
    logic [1:0]       op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic [63:0]      w_result;
    logic [31:0]      w_half;

    z_core_mult_unit u_mult (
        .op1        (rs1_q),
        .op2        (rs2_q),
        .op1_signed ((op_q == OP_MULH) || (op_q == OP_MULHSU)),
        .op2_signed (op_q == OP_MULH),
        .result     (w_result)
    );

    // MUL low half is identical for any signedness, so it rides the unsigned path
    assign w_half = (op_q == OP_MUL) ? w_result[31:0] : w_result[63:32];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            rs1_q      <= 32'd0;
            rs2_q      <= 32'd0;
            op_q       <= 2'd0;
            tag_q      <= '0;
            out_data_q <= 32'd0;
            out_tag_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            op_q       <= op_d;
            tag_q      <= tag_d;
            out_data_q <= out_data_d;
            out_tag_q  <= out_tag_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        op_d       = op_q;
        tag_d      = tag_q;
        out_data_d = out_data_q;
        out_tag_d  = out_tag_q;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        rs1_d   = in_rs1;
                        rs2_d   = in_rs2;
                        op_d    = in_op;
                        tag_d   = in_tag;
                        cnt_d   = CNT_INIT;
                        state_d = S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        out_data_d = w_half;
                        out_tag_d  = tag_q;
                        state_d    = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        busy      = (state_q == S_BUSY) || (state_q == S_DONE);
        out_data  = out_data_q;
        out_tag   = out_tag_q;
    end
endmodule

`default_nettype wire
